// File: rtl/data_sram_like_responder_pkg.sv
// rtl/data_sram_like_responder_pkg.sv - shared CPU data-bus definitions for the sram-like responder
package data_sram_like_responder_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int DEF_DATA_LAT = 1;
    localparam int DEF_ADDR_GAP = 0;

    localparam int IS_READ_W = 1;
    localparam int RDATA_W   = 32;

    // Two bits beyond log2(latency) keep the age subtraction unambiguous across wrap.
    function automatic int stamp_width(input int lat);
        return $clog2(lat) + 2;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << off;
            SZ_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/data_sram_like_responder_resp_fifo.sv
// rtl/data_sram_like_responder_resp_fifo.sv - synchronous response FIFO with head view
module data_sram_like_responder_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] slots [0:DEPTH-1];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = slots[rd_ptr];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            slots[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_sram_like_responder.sv
// rtl/data_sram_like_responder.sv - sram-like data-port memory responder with in-order delayed responses
module data_sram_like_responder
    import data_sram_like_responder_pkg::*;
#(
    parameter int MEM_AW     = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_LAT   = DEF_DATA_LAT,
    parameter int ADDR_GAP   = DEF_ADDR_GAP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    localparam int STAMP_W = stamp_width(DATA_LAT);
    localparam int ENTRY_W = IS_READ_W + RDATA_W + STAMP_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int GAP_W   = (ADDR_GAP > 0) ? $clog2(ADDR_GAP + 1) : 1;
    localparam logic [STAMP_W-1:0] LAT_M1 = STAMP_W'(DATA_LAT - 1);
    localparam bit LAT_ONE = (DATA_LAT == 1);

    logic [31:0]        mem [0:(1<<MEM_AW)-1];
    logic [MEM_AW-1:0]  idx;
    logic [31:0]        rd_word;
    logic [STAMP_W-1:0] cyc;
    logic [GAP_W-1:0]   gap_cnt;
    logic               accept;
    logic               push;
    logic               pop;
    logic               bypass;
    logic               head_due;
    logic               fire;
    logic               resp_read;
    logic [31:0]        resp_data;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               head_read;
    logic [31:0]        head_data;
    logic [STAMP_W-1:0] head_stamp;
    logic [STAMP_W-1:0] head_age;
    logic               unused_bits;

    assign idx        = addr[MEM_AW+1:2];
    assign rd_word    = mem[idx];
    assign addr_ok    = ~reset & (count < CNT_W'(FIFO_DEPTH)) & (gap_cnt == '0);
    assign accept     = req & addr_ok;
    assign push_entry = {~wr, rd_word, cyc};

    assign {head_read, head_data, head_stamp} = head;
    assign head_age  = cyc - head_stamp;
    assign head_due  = ~empty & (head_age >= LAT_M1);

    // At unit latency the response leaves on the acceptance edge itself, so the FIFO is skipped.
    assign bypass    = LAT_ONE & empty & accept;
    assign push      = accept & ~bypass;
    assign pop       = head_due;
    assign fire      = head_due | bypass;
    assign resp_read = head_due ? head_read : ~wr;
    assign resp_data = head_due ? head_data : rd_word;

    assign unused_bits = ^{full, addr[31:MEM_AW+2]};

    data_sram_like_responder_resp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) resp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head      (head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc     <= '0;
            gap_cnt <= '0;
            data_ok <= 1'b0;
            rdata   <= '0;
        end else begin
            cyc <= cyc + STAMP_W'(1);
            if (accept) begin
                gap_cnt <= GAP_W'(ADDR_GAP);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
            data_ok <= fire;
            rdata   <= (fire & resp_read) ? resp_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept & wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept & wr) begin
            assert ((wstrb & ~lane_mask(size, addr[1:0])) == 4'b0000);
        end
    end

endmodule

// File: tb/tb_data_sram_like_responder.sv
// tb/tb_data_sram_like_responder.sv - self-checking bench for data_sram_like_responder
module tb_data_sram_like_responder;
    import data_sram_like_responder_pkg::*;

    localparam int NI = 4;
    localparam int LAT_P   [NI] = '{1, 8, 2, 5};
    localparam int DEPTH_P [NI] = '{4, 4, 4, 2};
    localparam int GAP_P   [NI] = '{0, 0, 2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_v     [NI];
    logic        wr_v      [NI];
    logic [1:0]  size_v    [NI];
    logic [31:0] addr_v    [NI];
    logic [3:0]  wstrb_v   [NI];
    logic [31:0] wdata_v   [NI];
    logic        addr_ok_v [NI];
    logic        data_ok_v [NI];
    logic [31:0] rdata_v   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        data_sram_like_responder #(
            .MEM_AW     (8),
            .FIFO_DEPTH (DEPTH_P[g]),
            .DATA_LAT   (LAT_P[g]),
            .ADDR_GAP   (GAP_P[g])
        ) dut (
            .clk     (clk),
            .reset   (reset),
            .req     (req_v[g]),
            .wr      (wr_v[g]),
            .size    (size_v[g]),
            .addr    (addr_v[g]),
            .wstrb   (wstrb_v[g]),
            .wdata   (wdata_v[g]),
            .addr_ok (addr_ok_v[g]),
            .data_ok (data_ok_v[g]),
            .rdata   (rdata_v[g])
        );
    end

    typedef struct {
        int          due;
        logic        rd;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    resp_t       mq   [NI][$];
    logic [31:0] mmem [NI][256];
    int          gap_free [NI];
    int          cyc;
    logic        obs_aok [NI];
    logic        obs_dok [NI];
    logic [31:0] obs_rd  [NI];
    logic        acc     [NI];
    int          n_checks;
    int          n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pre_val(input int k, input int i);
        return 32'h1000_0000 * (k + 1) + 32'h0001_0101 * i + 32'h0000_0033;
    endfunction

    task automatic idle_all();
        for (int k = 0; k < NI; k++) begin
            req_v[k] = 1'b0; wr_v[k] = 1'b0; size_v[k] = SZ_WORD;
            addr_v[k] = '0; wstrb_v[k] = '0; wdata_v[k] = '0;
        end
    endtask

    task automatic drive(input int k, input logic w, input logic [1:0] s, input logic [31:0] a,
                         input logic [3:0] st, input logic [31:0] d);
        req_v[k] = 1'b1; wr_v[k] = w; size_v[k] = s;
        addr_v[k] = a; wstrb_v[k] = st; wdata_v[k] = d;
    endtask

    task automatic rand_req(input int k);
        int sz;
        int off;
        int idx;
        logic [3:0] lane;
        sz  = int'($urandom_range(0, 2));
        off = (sz == 0) ? int'($urandom_range(0, 3)) : (sz == 1) ? 2 * int'($urandom_range(0, 1)) : 0;
        lane = (sz == 0) ? 4'(1 << off) : (sz == 1) ? 4'(3 << off) : 4'hF;
        idx = int'($urandom_range(0, 15));
        req_v[k]   = ($urandom_range(0, 3) != 0);
        wr_v[k]    = 1'($urandom_range(0, 1));
        size_v[k]  = 2'(sz);
        addr_v[k]  = (32'($urandom_range(0, 7)) << 10) | 32'(idx * 4 + off);
        wstrb_v[k] = lane & 4'($urandom);
        wdata_v[k] = $urandom;
    endtask

    // Reference: each accepted request answers exactly DATA_LAT cycles later; occupancy is the
    // number of requests not yet answered.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            logic        exp_dok;
            logic        exp_aok;
            logic [31:0] w;
            int          widx;
            resp_t       r;
            obs_aok[k] = addr_ok_v[k];
            obs_dok[k] = data_ok_v[k];
            obs_rd[k]  = rdata_v[k];
            exp_dok = (mq[k].size() > 0) && (mq[k][0].due == cyc);
            check($sformatf("data_ok[%0d]", k), {31'b0, data_ok_v[k]}, {31'b0, exp_dok});
            if (exp_dok) begin
                check($sformatf("rdata[%0d]", k), rdata_v[k], mq[k][0].rd ? mq[k][0].data : 32'h0);
                void'(mq[k].pop_front());
            end
            exp_aok = !reset && (mq[k].size() < DEPTH_P[k]) && (cyc >= gap_free[k]);
            check($sformatf("addr_ok[%0d]", k), {31'b0, addr_ok_v[k]}, {31'b0, exp_aok});
            acc[k] = exp_aok && req_v[k];
            if (acc[k]) begin
                widx   = int'(addr_v[k][9:2]);
                w      = mmem[k][widx];
                r.due  = cyc + LAT_P[k];
                r.rd   = !wr_v[k];
                r.data = w;
                mq[k].push_back(r);
                if (wr_v[k]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb_v[k][b]) mmem[k][widx][8*b +: 8] = wdata_v[k][8*b +: 8];
                    end
                end
                gap_free[k] = cyc + GAP_P[k] + 1;
            end
            if (reset) begin
                mq[k].delete();
                gap_free[k] = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl [10];
        int          ptr [NI];
        int          done;
        int          j;
        int          cnt;
        int          first_dok;
        logic        aok7;
        logic        aok8;
        int          acc_t [$];
        logic [31:0] rdq [$];
        logic [31:0] got0;
        logic [31:0] got1;

        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        for (int k = 0; k < NI; k++) gap_free[k] = 0;
        idle_all();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset_addr_ok[%0d]", k), {31'b0, addr_ok_v[k]}, 32'h0);
            check($sformatf("reset_data_ok[%0d]", k), {31'b0, data_ok_v[k]}, 32'h0);
            check($sformatf("reset_rdata[%0d]", k), rdata_v[k], 32'h0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        step();
        for (int k = 0; k < NI; k++) check($sformatf("post_reset_addr_ok[%0d]", k), {31'b0, obs_aok[k]}, 32'h1);
        repeat (3) step();

        for (int k = 0; k < NI; k++) ptr[k] = 0;
        done = 0;
        for (int t = 0; t < 300 && done == 0; t++) begin
            for (int k = 0; k < NI; k++) begin
                if (ptr[k] < 16) drive(k, 1'b1, SZ_WORD, 32'(ptr[k] * 4), 4'hF, pre_val(k, ptr[k]));
                else req_v[k] = 1'b0;
            end
            step();
            done = 1;
            for (int k = 0; k < NI; k++) begin
                if (acc[k]) ptr[k]++;
                if (ptr[k] < 16) done = 0;
            end
        end
        for (int k = 0; k < NI; k++) check($sformatf("preload_done[%0d]", k), 32'(ptr[k]), 32'd16);
        idle_all();
        repeat (12) step();

        tbl[0] = '{1'b1, SZ_WORD, 32'h0000_0100, 4'hF, 32'h1234_5678, 32'h0000_0000};
        tbl[1] = '{1'b0, SZ_WORD, 32'h0000_0100, 4'h0, 32'h0000_0000, 32'h1234_5678};
        tbl[2] = '{1'b1, SZ_BYTE, 32'h0000_0102, 4'h4, 32'hAAAA_AAAA, 32'h0000_0000};
        tbl[3] = '{1'b0, SZ_WORD, 32'h0000_0100, 4'h0, 32'h0000_0000, 32'h12AA_5678};
        tbl[4] = '{1'b1, SZ_WORD, 32'h0000_0100, 4'h0, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[5] = '{1'b0, SZ_BYTE, 32'h0000_0101, 4'h0, 32'h0000_0000, 32'h12AA_5678};
        tbl[6] = '{1'b1, SZ_WORD, 32'h0000_0104, 4'hF, 32'h0000_0000, 32'h0000_0000};
        tbl[7] = '{1'b1, SZ_HALF, 32'h0000_0106, 4'hC, 32'hBEEF_BEEF, 32'h0000_0000};
        tbl[8] = '{1'b0, SZ_WORD, 32'h0000_1104, 4'h0, 32'h0000_0000, 32'hBEEF_0000};
        tbl[9] = '{1'b0, SZ_WORD, 32'h0000_0100, 4'h0, 32'h0000_0000, 32'h12AA_5678};
        for (int i = 0; i < 10; i++) begin
            drive(0, tbl[i].wr, tbl[i].size, tbl[i].addr, tbl[i].strb, tbl[i].wdata);
            step();
            check($sformatf("tbl%0d_accept", i), {31'b0, obs_aok[0]}, 32'h1);
            idle_all();
            step();
            check($sformatf("tbl%0d_data_ok", i), {31'b0, obs_dok[0]}, 32'h1);
            check($sformatf("tbl%0d_rdata", i), obs_rd[0], tbl[i].exp_rdata);
        end
        repeat (2) step();

        cnt = 0;
        for (int t = 0; t < 5; t++) begin
            if (t < 4) drive(0, 1'b0, SZ_WORD, 32'(t * 4), 4'h0, 32'h0);
            else idle_all();
            step();
            if (t > 0 && obs_dok[0]) cnt++;
        end
        check("back_to_back_data_ok", 32'(cnt), 32'd4);
        repeat (3) step();

        cnt = 0; j = 0; first_dok = -1; aok7 = 1'b1; aok8 = 1'b0;
        for (int t = 0; t < 16; t++) begin
            drive(1, 1'b0, SZ_WORD, 32'(j * 4), 4'h0, 32'h0);
            step();
            if (t < 8 && obs_aok[1]) cnt++;
            if (acc[1]) j++;
            if (obs_dok[1] && first_dok < 0) first_dok = t;
            if (t == 7) aok7 = obs_aok[1];
            if (t == 8) aok8 = obs_aok[1];
        end
        check("lat8_accepts_until_full", 32'(cnt), 32'd4);
        check("lat8_first_data_ok", 32'(first_dok), 32'd8);
        check("lat8_addr_ok_full", {31'b0, aok7}, 32'h0);
        check("lat8_addr_ok_after_pop", {31'b0, aok8}, 32'h1);
        idle_all();
        repeat (14) step();

        j = 0;
        for (int t = 0; t < 12; t++) begin
            if (j < 3) drive(2, 1'b0, SZ_WORD, 32'(j * 4), 4'h0, 32'h0);
            else req_v[2] = 1'b0;
            step();
            if (obs_aok[2] && req_v[2]) acc_t.push_back(t);
            if (acc[2]) j++;
            if (obs_dok[2]) rdq.push_back(obs_rd[2]);
        end
        check("gap_accept_count", 32'(acc_t.size()), 32'd3);
        for (int i = 0; i < acc_t.size() && i < 3; i++) check($sformatf("gap_accept_cycle%0d", i), 32'(acc_t[i]), 32'(3 * i));
        check("gap_resp_count", 32'(rdq.size()), 32'd3);
        for (int i = 0; i < rdq.size() && i < 3; i++) check($sformatf("gap_rdata%0d", i), rdq[i], pre_val(2, i));
        idle_all();
        repeat (4) step();

        j = 0;
        for (int t = 0; t < 4; t++) begin
            if (j < 3) drive(1, 1'b0, SZ_WORD, 32'(j * 4), 4'h0, 32'h0);
            else req_v[1] = 1'b0;
            step();
            if (acc[1]) j++;
        end
        check("rst_outstanding", 32'(j), 32'd3);
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        idle_all();
        cnt = 0;
        repeat (12) begin
            step();
            if (obs_dok[1]) cnt++;
        end
        check("rst_dropped_no_data_ok", 32'(cnt), 32'd0);
        drive(0, 1'b0, SZ_WORD, 32'h0000_0100, 4'h0, 32'h0);
        drive(1, 1'b0, SZ_WORD, 32'h0000_0014, 4'h0, 32'h0);
        got0 = 32'hDEAD_DEAD;
        got1 = 32'hDEAD_DEAD;
        for (int t = 0; t < 10; t++) begin
            step();
            idle_all();
            if (obs_dok[0]) got0 = obs_rd[0];
            if (obs_dok[1]) got1 = obs_rd[1];
        end
        check("rst_mem_kept0", got0, 32'h12AA_5678);
        check("rst_mem_kept1", got1, pre_val(1, 5));

        for (int t = 0; t < 800; t++) begin
            for (int k = 0; k < NI; k++) rand_req(k);
            step();
        end
        idle_all();
        repeat (12) step();
        for (int k = 0; k < NI; k++) check($sformatf("drained[%0d]", k), 32'(mq[k].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_sram_like_responder.md
Name: data_sram_like_responder

Overview:
- Memory-side responder for the CPU data port using the handshaked sram-like protocol (req/addr_ok, then data_ok). It replaces the fixed single-cycle data SRAM behind the MEM stage.
- Accepts one request per cycle when able and performs the access in the acceptance cycle. Responses are returned strictly in order after a programmable latency.
- Serves as both the simulation memory model and the reference slave for CPU stage verification.

Parameters:
- MEM_AW, 12, word-index width; memory holds 2^MEM_AW 32-bit words, indexed by addr[MEM_AW+1:2].
- FIFO_DEPTH, 4, maximum accepted-but-unanswered requests; power of two, at least 1.
- DATA_LAT, 1, minimum cycles from acceptance to data_ok; at least 1.
- ADDR_GAP, 0, cycles addr_ok stays low after each acceptance; 0 allows back-to-back acceptance.

Ports:
- clk  in  1  clock, all state on the rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  request valid
- wr  in  1  1 = write, 0 = read
- size  in  2  0 = byte, 1 = half, 2 = word
- addr  in  32  byte address
- wstrb  in  4  byte write enables, used only when wr = 1
- wdata  in  32  write data, byte lanes already replicated by the initiator
- addr_ok  out  1  request accepted this cycle when req is also high
- data_ok  out  1  one-cycle response pulse, one per accepted request, in order
- rdata  out  32  read word; valid with data_ok for reads, 0 for writes

Behaviour:
- Reset, synchronous active-high:
  - addr_ok = 0, data_ok = 0, rdata = 0.
  - FIFO emptied, gap counter cleared.
  - Memory array is not reset.
  - Reset during outstanding requests drops them; no data_ok is issued for dropped requests.
- Acceptance: a request is accepted when req & addr_ok at a rising edge.
  - addr_ok is a function of registered state only; it never depends on req or same-cycle data_ok.
  - addr_ok = ~reset & (count < FIFO_DEPTH) & (gap_cnt == 0).
  - A full FIFO blocks acceptance even if the head pops in the same cycle.
- Gap counter: on acceptance it loads ADDR_GAP, then decrements to 0 once per cycle.
- Access at acceptance:
  - Write: for each i with wstrb[i] = 1, mem[idx] byte i <= wdata byte i. wstrb = 0 is a no-op but still gets a response.
  - Read: captures mem[idx] as it was before any write in the same edge. Only one request is accepted per edge, so no conflict arises.
  - A read accepted the cycle after a write to the same word sees the new data.
- Address handling: addr[1:0] and bits above MEM_AW+1 are ignored. The full word is always returned; the initiator performs byte/half extraction.
- size is not used for the access. A simulation-only check flags wr with a wstrb that is inconsistent with size/addr[1:0].
- Response FIFO:
  - Each entry holds {is_read, rdata, accept_stamp}, where accept_stamp comes from a free-running counter. Counter width must exceed log2(DATA_LAT) + 1 so wrap-around is safe.
  - The head is eligible once the current cycle is at least acceptance + DATA_LAT.
  - data_ok = 1 for exactly one cycle per eligible head; the head pops on that same edge. rdata = head data if is_read, else 0.
- Timing: with DATA_LAT = 1, a request accepted at edge N gets data_ok in the cycle after edge N. Back-to-back acceptances give back-to-back data_ok.
- Outputs: data_ok and rdata are registered.
- The initiator must always accept data_ok; there is no response backpressure.
- Count updates: a simultaneous accept and pop leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared package (alongside the other CPU bus definitions):
  - size encodings SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2.
  - Default values for DATA_LAT and ADDR_GAP.
  - Response-entry field widths.
- One sub-module, resp_fifo: a synchronous FIFO parameterised by width and depth, with push, pop, full, empty, count, and head outputs. Timestamp eligibility logic and the memory array stay in the top level.

Test Plan:
- Reset then idle: addr_ok = 0 during reset and 1 the cycle after. data_ok stays 0 with no req.
- Write word 0x12345678 to 0x100 (wstrb = 1111), then read 0x100 with DATA_LAT = 1: data_ok one cycle after each acceptance, read rdata = 0x12345678, write rdata = 0.
- Byte write wstrb = 0100, wdata = 0xAAAAAAAA to 0x100, then read: rdata = 0x12AA5678. A wstrb = 0000 write leaves the word unchanged but still pulses data_ok.
- FIFO_DEPTH = 4, DATA_LAT = 8, req held high: exactly 4 acceptances, then addr_ok = 0. The first data_ok comes 8 cycles after the first acceptance. addr_ok returns the cycle after the first pop.
- ADDR_GAP = 2, req held high: acceptances at cycles 1, 4, 7. Responses stay in order, with rdata matching the preloaded addresses 0x0, 0x4, 0x8.
- Reset asserted with 3 requests outstanding: no data_ok afterwards. Memory still holds previously written values on a later read.
